fft_out_serializer: RTL and testbench
=====================================

Name: fft_out_serializer

Overview:
- Downstream stage of the FFT top.
- Consumes the two-lane output beat (data0/data1, out_vld/out_rdy) that the FFT top drives from its output memory.
- Emits a single-lane, one-sample-per-cycle stream with a registered squared magnitude, a sample index, and frame markers.
- Output feeds the spectrum/peak logic. Its in_rdy drives the FFT top's out_rdy.

Parameters:
- N, 4, FFT memory address width; one frame is 2^N beats, i.e. 2^(N+1) samples.
- DW, 32, sample width; [DW-1:DW/2] = real part, [DW/2-1:0] = imaginary part, both signed two's complement.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rstn  input  1  synchronous, active-low reset.
- in_vld  input  1  input beat valid (FFT top out_vld).
- in_data0  input  DW  lane-0 sample; earlier in output order.
- in_data1  input  DW  lane-1 sample; later in output order.
- in_rdy  output  1  beat accepted when in_vld && in_rdy.
- out_vld  output  1  output sample valid.
- out_rdy  input  1  downstream ready; a sample transfers when out_vld && out_rdy.
- out_data  output  DW  current sample.
- out_mag  output  DW  re^2 + im^2, unsigned.
- out_idx  output  N+1  sample position within the frame.
- out_sof  output  1  asserted with sample index 0.
- out_eof  output  1  asserted with sample index 2^(N+1)-1.

Behaviour:
- Reset (rstn=0 at clk edge): state=IDLE, pair/mag registers=0, out_idx=0. in_rdy is gated by rstn, so it is 0 while rstn=0. out_vld=0, out_data=0, out_mag=0, out_sof=0, out_eof=0.
- Reset mid-frame discards all buffered samples; the next frame restarts at idx 0.
- States: IDLE (empty), L0 (presenting lane 0), L1 (presenting lane 1).
- in_rdy = rstn && (state==IDLE || (state==L1 && out_rdy)). This is combinational from out_rdy, which is required for 1 sample/cycle sustained throughput.
- Capture on input handshake: p0<=in_data0, p1<=in_data1, m0<=sq(in_data0), m1<=sq(in_data1). Magnitudes are computed at capture, so out_mag is aligned with out_data with no extra latency.
- State transitions:
  - IDLE: input handshake -> L0.
  - L0: out_rdy -> L1; otherwise hold.
  - L1: out_rdy && in_vld -> capture, -> L0. out_rdy && !in_vld -> IDLE. !out_rdy -> hold.
- Outputs:
  - out_vld = (state!=IDLE).
  - out_data/out_mag = p0/m0 in L0, p1/m1 in L1, 0 in IDLE.
- Latency: first sample valid 1 cycle after input handshake; second sample the cycle after the first transfers.
- Stall: while out_rdy=0, out_data, out_mag and out_idx are stable and in_rdy=0.
- sq(x) = re*re + im*im. Each product is a signed 16x16 multiply, taken as unsigned 32 bits; the sum is DW bits unsigned.
  - Max value (-32768, -32768) = 0x8000_0000; no overflow.
- out_idx increments on each output handshake and wraps 2^(N+1)-1 -> 0.
  - out_sof = out_vld && out_idx==0.
  - out_eof = out_vld && out_idx==all-ones.
- No frame boundary is enforced on input; frames are defined purely by the output sample count.
- Upstream zero-when-invalid data is never captured, because capture requires in_vld.

Test Plan:
1. Reset hold: rstn=0 for 3 cycles, in_vld=1, data=0x1234_5678 -> in_rdy=0, out_vld=0, out_data=0 throughout; after release, the first capture gives out_idx=0.
2. Single beat, out_rdy=1: in_data0=0x0003_0004, in_data1=0xFFFD_0000 -> expected sequence:
   - T+1: out_data=0x00030004, out_mag=25, idx=0, sof=1.
   - T+2: out_data=0xFFFD0000, out_mag=9, idx=1.
   - T+3: out_vld=0.
3. Streaming, in_vld and out_rdy held at 1 for 16 beats -> in_rdy pattern 1,0,1,0...; out_vld=1 every cycle after the first; idx 0..31; eof only at idx 31; the 17th beat's lane 0 has idx=0, sof=1.
4. Backpressure: out_rdy=0 for 5 cycles in L0 -> out_data, out_mag and idx frozen, in_rdy=0; on release, lane 0 and then lane 1 emit in order with no loss or duplication.
5. Magnitude extremes:
   - 0x8000_8000 -> out_mag=0x8000_0000.
   - 0x7FFF_7FFF -> 0x7FFE_0002.
   - 0x0000_0000 -> 0.
6. Reset mid-frame after 7 output samples, with a beat buffered in L1 -> buffered sample dropped; the next accepted beat outputs idx=0, sof=1.

Source files
------------

// File: rtl/fft_out_serializer_if.sv
// Bus between the FFT top output (two-lane beats) and the serializer, plus the
// serializer's single-lane sample stream toward the spectrum/peak logic.
//   in_vld/in_data0/in_data1/in_rdy : two-lane input beat handshake
//   out_vld/out_rdy                 : single-lane output handshake
//   out_data/out_mag/out_idx        : sample, squared magnitude, index in frame
//   out_sof/out_eof                 : frame start / end markers
// Modport slave is the serializer's view; master is the driver/sink view.
interface fft_out_serializer_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 32
);
  logic          in_vld;
  logic [DW-1:0] in_data0;
  logic [DW-1:0] in_data1;
  logic          in_rdy;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_data;
  logic [DW-1:0] out_mag;
  logic [N:0]    out_idx;
  logic          out_sof;
  logic          out_eof;

  modport slave (
    input  in_vld, in_data0, in_data1, out_rdy,
    output in_rdy, out_vld, out_data, out_mag, out_idx, out_sof, out_eof
  );

  modport master (
    output in_vld, in_data0, in_data1, out_rdy,
    input  in_rdy, out_vld, out_data, out_mag, out_idx, out_sof, out_eof
  );
endinterface

// File: rtl/fft_out_serializer.sv
// Serializes two-lane FFT output beats into a one-sample-per-cycle stream.
// Each sample carries its squared magnitude (computed at capture so it lines up
// with the data), its index within a 2^(N+1)-sample frame and SOF/EOF markers.
// Ports:
//   clk  : system clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : fft_out_serializer_if slave modport (input beat + output stream)
module fft_out_serializer #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  fft_out_serializer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StL0, StL1} state_e;

  state_e        r_state;
  state_e        w_state_d;
  logic [DW-1:0] r_p0, r_p1;
  logic [DW-1:0] r_m0, r_m1;
  logic [N:0]    r_idx;

  logic          w_in_hs;
  logic          w_out_hs;
  logic          w_in_rdy;
  logic          w_out_vld;

  // re^2 + im^2 with signed halves; the sum of two squares of 16-bit values
  // peaks at 0x8000_0000 so it fits DW bits unsigned.
  function automatic logic [DW-1:0] sq(input logic [DW-1:0] x);
    logic signed [DW-1:0] re_ext;
    logic signed [DW-1:0] im_ext;
    logic signed [DW-1:0] rr;
    logic signed [DW-1:0] ii;
    re_ext = {{(DW/2){x[DW-1]}}, x[DW-1:DW/2]};
    im_ext = {{(DW/2){x[DW/2-1]}}, x[DW/2-1:0]};
    rr = re_ext * re_ext;
    ii = im_ext * im_ext;
    return rr + ii;
  endfunction

  // Combinational path from out_rdy lets a new beat land in the same cycle the
  // last lane leaves, which is what sustains one sample per cycle.
  assign w_in_rdy  = rstn && ((r_state == StIdle) || ((r_state == StL1) && bus.out_rdy));
  assign w_out_vld = (r_state != StIdle);
  assign w_in_hs   = bus.in_vld && w_in_rdy;
  assign w_out_hs  = w_out_vld && bus.out_rdy;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (w_in_hs) w_state_d = StL0;
      StL0:   if (bus.out_rdy) w_state_d = StL1;
      StL1: begin
        if (bus.out_rdy) w_state_d = bus.in_vld ? StL0 : StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= StIdle;
      r_p0    <= '0;
      r_p1    <= '0;
      r_m0    <= '0;
      r_m1    <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_in_hs) begin
        r_p0 <= bus.in_data0;
        r_p1 <= bus.in_data1;
        r_m0 <= sq(bus.in_data0);
        r_m1 <= sq(bus.in_data1);
      end
      // Natural wrap of the N+1 bit counter delimits frames.
      if (w_out_hs) r_idx <= r_idx + 1'b1;
    end
  end

  always_comb begin
    bus.out_data = '0;
    bus.out_mag  = '0;
    unique case (r_state)
      StL0: begin
        bus.out_data = r_p0;
        bus.out_mag  = r_m0;
      end
      StL1: begin
        bus.out_data = r_p1;
        bus.out_mag  = r_m1;
      end
      default: begin
        bus.out_data = '0;
        bus.out_mag  = '0;
      end
    endcase
  end

  assign bus.in_rdy  = w_in_rdy;
  assign bus.out_vld = w_out_vld;
  assign bus.out_idx = r_idx;
  assign bus.out_sof = w_out_vld && (r_idx == '0);
  assign bus.out_eof = w_out_vld && (&r_idx);

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed self-checking bench for fft_out_serializer (N=4, DW=32).
module tb_fft_out_serializer;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_bad;

  fft_out_serializer_if #(.N(N), .DW(DW)) bus ();

  fft_out_serializer #(.N(N), .DW(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] data, input logic [31:0] mag,
                         input int idx, input logic sof, input logic eof);
    chk({tag, ".vld"},  bus.out_vld,  1'b1);
    chk({tag, ".data"}, bus.out_data, data);
    chk({tag, ".mag"},  bus.out_mag,  mag);
    chk({tag, ".idx"},  bus.out_idx,  64'(idx));
    chk({tag, ".sof"},  bus.out_sof,  sof);
    chk({tag, ".eof"},  bus.out_eof,  eof);
  endtask

  initial begin
    logic [31:0] sd;
    n_cmp = 0;
    n_bad = 0;

    // 1. Reset hold with valid input present.
    rstn = 1'b0;
    bus.in_vld   = 1'b1;
    bus.in_data0 = 32'h1234_5678;
    bus.in_data1 = 32'h1234_5678;
    bus.out_rdy  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst.in_rdy",   bus.in_rdy,   1'b0);
      chk("rst.out_vld",  bus.out_vld,  1'b0);
      chk("rst.out_data", bus.out_data, 32'h0);
      chk("rst.idx",      bus.out_idx,  5'd0);
    end
    bus.in_vld = 1'b0;
    rstn = 1'b1;
    tick();
    chk("idle.in_rdy",  bus.in_rdy,  1'b1);
    chk("idle.out_vld", bus.out_vld, 1'b0);

    // 2. Single beat, out_rdy=1.
    bus.in_vld   = 1'b1;
    bus.in_data0 = 32'h0003_0004;
    bus.in_data1 = 32'hFFFD_0000;
    tick();
    bus.in_vld = 1'b0;
    chk_out("single.l0", 32'h0003_0004, 32'd25, 0, 1'b1, 1'b0);
    chk("single.l0.in_rdy", bus.in_rdy, 1'b0);
    tick();
    chk_out("single.l1", 32'hFFFD_0000, 32'd9, 1, 1'b0, 1'b0);
    chk("single.l1.in_rdy", bus.in_rdy, 1'b1);
    tick();
    chk("single.end.vld",  bus.out_vld,  1'b0);
    chk("single.end.data", bus.out_data, 32'h0);

    // 3. Streaming: sample s carries {s, s} so its magnitude is 2*s*s.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    bus.in_vld   = 1'b1;
    bus.out_rdy  = 1'b1;
    bus.in_data0 = {16'd0, 16'd0};
    bus.in_data1 = {16'd1, 16'd1};
    #1;
    chk("stream.idle.in_rdy", bus.in_rdy, 1'b1);
    tick();
    for (int s = 0; s < 34; s++) begin
      sd = {16'(s), 16'(s)};
      chk_out("stream", sd, 32'(2 * s * s), s % 32, (s % 32) == 0, (s % 32) == 31);
      chk("stream.in_rdy", bus.in_rdy, 1'((s % 2) == 1));
      if ((s % 2) == 1) begin
        bus.in_data0 = {16'(s + 1), 16'(s + 1)};
        bus.in_data1 = {16'(s + 2), 16'(s + 2)};
      end
      tick();
    end
    bus.in_vld = 1'b0;
    chk_out("stream.s34", {16'd34, 16'd34}, 32'(2 * 34 * 34), 2, 1'b0, 1'b0);
    tick();
    chk_out("stream.s35", {16'd35, 16'd35}, 32'(2 * 35 * 35), 3, 1'b0, 1'b0);
    tick();
    chk("stream.drain.vld", bus.out_vld, 1'b0);

    // 4. Backpressure in L0 for 5 cycles.
    bus.in_vld   = 1'b1;
    bus.in_data0 = 32'h0001_0002;
    bus.in_data1 = 32'h0002_FFFD;
    tick();
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_out("bp.hold", 32'h0001_0002, 32'd5, 4, 1'b0, 1'b0);
      chk("bp.in_rdy", bus.in_rdy, 1'b0);
      tick();
    end
    bus.out_rdy = 1'b1;
    chk_out("bp.l0", 32'h0001_0002, 32'd5, 4, 1'b0, 1'b0);
    tick();
    chk_out("bp.l1", 32'h0002_FFFD, 32'd13, 5, 1'b0, 1'b0);
    tick();
    chk("bp.end.vld", bus.out_vld, 1'b0);
    chk("bp.end.idx", bus.out_idx, 5'd6);

    // 5. Magnitude extremes.
    bus.in_vld   = 1'b1;
    bus.in_data0 = 32'h8000_8000;
    bus.in_data1 = 32'h7FFF_7FFF;
    tick();
    bus.in_data0 = 32'h0000_0000;
    bus.in_data1 = 32'hFFFF_0001;
    chk_out("mag.min", 32'h8000_8000, 32'h8000_0000, 6, 1'b0, 1'b0);
    tick();
    chk_out("mag.max", 32'h7FFF_7FFF, 32'h7FFE_0002, 7, 1'b0, 1'b0);
    tick();
    bus.in_vld = 1'b0;
    chk_out("mag.zero", 32'h0, 32'h0, 8, 1'b0, 1'b0);
    tick();
    chk_out("mag.m1p1", 32'hFFFF_0001, 32'd2, 9, 1'b0, 1'b0);
    tick();
    chk("mag.end.vld", bus.out_vld, 1'b0);

    // 6. Reset mid-frame with a beat buffered in L1.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    bus.in_vld   = 1'b1;
    bus.in_data0 = 32'h0000_0011;
    bus.in_data1 = 32'h0000_0022;
    for (int i = 0; i < 8; i++) tick();
    chk_out("mid.s7", 32'h0000_0022, 32'd1156, 7, 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    chk("mid.rst.in_rdy", bus.in_rdy, 1'b0);
    tick();
    chk("mid.rst.vld",  bus.out_vld,  1'b0);
    chk("mid.rst.data", bus.out_data, 32'h0);
    rstn = 1'b1;
    bus.in_data0 = 32'h0002_0000;
    bus.in_data1 = 32'h0000_0003;
    tick();
    bus.in_vld = 1'b0;
    chk_out("mid.new.l0", 32'h0002_0000, 32'd4, 0, 1'b1, 1'b0);
    tick();
    chk_out("mid.new.l1", 32'h0000_0003, 32'd9, 1, 1'b0, 1'b0);
    tick();
    chk("mid.end.vld", bus.out_vld, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
